// File: rtl/edge_rle_packer.sv
// edge_rle_packer: thresholds an 8-bit Sobel edge-magnitude stream to edge/no-edge
// classes and run-length encodes each image line. The encoded words go into a
// first-word-fall-through FIFO for the downlink formatter. The input stream cannot
// stall, so a cycle whose words do not fit is dropped whole and a sticky overflow
// flag is set.
//
// Optional build macro: EDGE_RLE_HYST_EN. When it is defined, pixels after the first
// of a line use a hysteresis threshold (thr - HYST, floored at 0) while inside an
// edge run. When it is undefined, the plain threshold applies everywhere.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   valid      edge_in carries a pixel this cycle
//   edge_in    unsigned edge magnitude
//   thresh     threshold, sampled on the first pixel of each line
//   rle_valid  FIFO head word present
//   rle_ready  consumer accepts the head word
//   rle_data   {class, eol, len[RUN_W-1:0]}; zero when rle_valid is low
//   overflow   sticky, set once any word has been dropped
module edge_rle_packer #(
    parameter int unsigned IMG_WIDTH  = 3000,
    parameter int unsigned RUN_W      = 14,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned HYST       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [7:0]       edge_in,
    input  logic [7:0]       thresh,
    output logic             rle_valid,
    input  logic             rle_ready,
    output logic [RUN_W+1:0] rle_data,
    output logic             overflow
);

    localparam int unsigned COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
    localparam logic [RUN_W-1:0] RUN_MAX   = '1;
    localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);
    localparam logic [7:0]       THR_RESET = 8'd128;

    // The FIFO pointers wrap by natural overflow, which needs a power-of-two depth.
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (HYST > 255))
    begin : g_bad_param
        $error("edge_rle_packer: FIFO_DEPTH must be a power of two >= 2, HYST <= 255");
    end

    logic [COL_W-1:0] col_q, col_d;
    logic             cur_bit_q, cur_bit_d;
    logic [RUN_W-1:0] run_len_q, run_len_d;
    logic [7:0]       thr_q, thr_d;
    logic             overflow_q, overflow_d;

    logic [RUN_W+1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             first_px;
    logic             last_px;
    logic             pix_bit;
    logic [RUN_W-1:0] run_inc;
    logic [RUN_W+1:0] word0, word1;
    logic [1:0]       n_push;
    logic [1:0]       n_acc;
    logic             pop;
    logic             drop;
    logic [CNT_W-1:0] free_slots;

    assign first_px = (col_q == '0);
    assign last_px  = (col_q == COL_LAST);
    assign run_inc  = run_len_q + 1'b1;

`ifdef EDGE_RLE_HYST_EN
    logic [7:0] thr_lo;

    // Inside an edge run the pixel only drops out below thr - HYST (floored at 0).
    always_comb begin
        thr_lo = '0;
        if (32'(thr_q) >= HYST) begin
            thr_lo = 8'(32'(thr_q) - HYST);
        end
        if (first_px) begin
            pix_bit = (edge_in >= thresh);
        end else if (cur_bit_q) begin
            pix_bit = (edge_in >= thr_lo);
        end else begin
            pix_bit = (edge_in >= thr_q);
        end
    end
`else
    // The first pixel of a line compares against the incoming threshold directly.
    assign pix_bit = (edge_in >= (first_px ? thresh : thr_q));
`endif

    // Run tracking and word generation; up to two words per pixel.
    always_comb begin
        col_d     = col_q;
        cur_bit_d = cur_bit_q;
        run_len_d = run_len_q;
        thr_d     = thr_q;
        word0     = '0;
        word1     = '0;
        n_push    = 2'd0;
        if (valid) begin
            col_d = last_px ? '0 : col_q + 1'b1;
            if (first_px) begin
                thr_d     = thresh;
                cur_bit_d = pix_bit;
                run_len_d = RUN_ONE;
                if (last_px) begin
                    // Single-pixel lines close immediately.
                    word0  = {pix_bit, 1'b1, RUN_ONE};
                    n_push = 2'd1;
                end
            end else if ((pix_bit == cur_bit_q) && (run_len_q != RUN_MAX)) begin
                run_len_d = run_inc;
                if (last_px) begin
                    word0  = {cur_bit_q, 1'b1, run_inc};
                    n_push = 2'd1;
                end
            end else begin
                // Class change or saturated run: close the current run first.
                word0     = {cur_bit_q, 1'b0, run_len_q};
                cur_bit_d = pix_bit;
                run_len_d = RUN_ONE;
                n_push    = 2'd1;
                if (last_px) begin
                    word1  = {pix_bit, 1'b1, RUN_ONE};
                    n_push = 2'd2;
                end
            end
        end
    end

    // FIFO bookkeeping. A same-cycle pop frees a slot for this cycle's pushes; if the
    // words still do not fit, all of them are dropped together.
    always_comb begin
        pop        = (count_q != '0) && rle_ready;
        free_slots = CNT_W'(FIFO_DEPTH) - count_q + CNT_W'(pop);
        drop       = (CNT_W'(n_push) > free_slots);
        n_acc      = drop ? 2'd0 : n_push;
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d   = wr_ptr_q + PTR_W'(n_acc);
        count_d    = count_q - CNT_W'(pop) + CNT_W'(n_acc);
        overflow_d = overflow_q | drop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q      <= '0;
            cur_bit_q  <= 1'b0;
            run_len_q  <= '0;
            thr_q      <= THR_RESET;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            col_q      <= col_d;
            cur_bit_q  <= cur_bit_d;
            run_len_q  <= run_len_d;
            thr_q      <= thr_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (n_acc != 2'd0) begin
            mem_q[wr_ptr_q] <= word0;
        end
        if (n_acc == 2'd2) begin
            mem_q[wr_ptr_q + PTR_W'(1)] <= word1;
        end
    end

    assign rle_valid = (count_q != '0);
    assign rle_data  = rle_valid ? mem_q[rd_ptr_q] : '0;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_edge_rle_packer.sv
// Bench for edge_rle_packer with a short line, narrow runs and a tiny FIFO so that
// line ends, saturation splits and overflow all occur often.
module tb_edge_rle_packer;

    localparam int W      = 8;
    localparam int RW     = 3;
    localparam int FD     = 4;
    localparam int HY     = 16;
    localparam int MAXRUN = (1 << RW) - 1;

    logic          clk;
    logic          rst;
    logic          valid;
    logic [7:0]    edge_in;
    logic [7:0]    thresh;
    logic          rle_valid;
    logic          rle_ready;
    logic [RW+1:0] rle_data;
    logic          overflow;

    edge_rle_packer #(
        .IMG_WIDTH  (W),
        .RUN_W      (RW),
        .FIFO_DEPTH (FD),
        .HYST       (HY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid     (valid),
        .edge_in   (edge_in),
        .thresh    (thresh),
        .rle_valid (rle_valid),
        .rle_ready (rle_ready),
        .rle_data  (rle_data),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: the class bits of the current line, the threshold in force,
    // the expected FIFO contents and the sticky overflow flag.
    int            col_m;
    logic [7:0]    thr_m;
    logic          bits_m [W];
    logic [RW+1:0] q_m [$];
    logic          ovf_m;
    int            ch_cls [W];
    int            ch_len [W];
    logic [7:0]    line_px [W];

    // Split the first n class bits of the line into runs of equal class, each run cut
    // into chunks of at most MAXRUN pixels. Returns the number of chunks.
    function automatic int chunkify(input int n);
        int k = 0;
        for (int i = 0; i < n; i++) begin
            if (i == 0 || bits_m[i] != bits_m[i-1] || ch_len[k-1] == MAXRUN) begin
                ch_cls[k] = int'(bits_m[i]);
                ch_len[k] = 1;
                k++;
            end else begin
                ch_len[k-1]++;
            end
        end
        return k;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs at the falling edge, advance the model, check after the
    // rising edge.
    task automatic cyc(input logic v, input logic [7:0] e, input logic [7:0] t,
                       input logic rdy, input logic r);
        logic [RW+1:0] pend [$];
        int  kprev, nb, free;
        bit  pop;
        logic b;
        @(negedge clk);
        valid     = v;
        edge_in   = e;
        thresh    = t;
        rle_ready = rdy;
        rst       = r;
        if (r) begin
            col_m = 0;
            thr_m = 8'd128;
            q_m.delete();
            ovf_m = 1'b0;
        end else begin
            pop = (q_m.size() > 0) && rdy;
            if (v) begin
                if (col_m == 0) thr_m = t;
                b = (e >= thr_m);
`ifdef EDGE_RLE_HYST_EN
                if (col_m != 0 && bits_m[col_m-1])
                    b = (int'(e) >= ((int'(thr_m) >= HY) ? int'(thr_m) - HY : 0));
`endif
                bits_m[col_m] = b;
                // Chunks that became closed by this pixel are emitted now.
                kprev = (col_m == 0) ? 0 : chunkify(col_m) - 1;
                nb    = chunkify(col_m + 1);
                for (int i = kprev; i < nb - 1; i++)
                    pend.push_back({ch_cls[i][0], 1'b0, RW'(ch_len[i])});
                if (col_m == W - 1)
                    pend.push_back({ch_cls[nb-1][0], 1'b1, RW'(ch_len[nb-1])});
                col_m = (col_m == W - 1) ? 0 : col_m + 1;
            end
            free = FD - q_m.size() + int'(pop);
            if (pop) void'(q_m.pop_front());
            if (pend.size() > free) ovf_m = 1'b1;
            else foreach (pend[i]) q_m.push_back(pend[i]);
        end
        @(posedge clk);
        #1;
        chk("rle_valid", 32'(rle_valid), 32'(q_m.size() != 0));
        if (q_m.size() != 0) chk("rle_data", 32'(rle_data), 32'(q_m[0]));
        else chk("rle_data_known", 32'($isunknown(rle_data)), 32'd0);
        chk("overflow", 32'(overflow), 32'(ovf_m));
    endtask

    task automatic feed_line(input logic [7:0] t, input logic rdy);
        for (int i = 0; i < W; i++) cyc(1'b1, line_px[i], t, rdy, 1'b0);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 8'h80, rdy, 1'b0);
    endtask

    initial begin
        logic [7:0] e_prev;
        rst       = 1'b1;
        valid     = 1'b0;
        edge_in   = '0;
        thresh    = 8'h80;
        rle_ready = 1'b0;
        col_m     = 0;
        thr_m     = 8'd128;
        ovf_m     = 1'b0;

        // Reset state.
        cyc(1'b0, 8'h00, 8'h80, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 8'h80, 1'b0, 1'b1);

        // Mixed runs, consumer always ready.
        line_px = '{8'h00, 8'h00, 8'hC8, 8'hC8, 8'hC8, 8'h00, 8'h00, 8'h00};
        feed_line(8'h80, 1'b1);
        idle(3, 1'b1);

        // Class change on the last pixel: two words in one cycle.
        line_px = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
        feed_line(8'h80, 1'b0);
        chk("two_word_head", 32'(rle_data), 32'(5'b00111));
        idle(1, 1'b1);
        chk("two_word_second", 32'(rle_data), 32'(5'b11001));
        idle(2, 1'b1);

        // Saturation split, including a split on the last pixel.
        line_px = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        feed_line(8'h80, 1'b1);
        idle(3, 1'b1);

        // Overflow with the consumer stalled, then drain.
        line_px = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF};
        feed_line(8'h80, 1'b0);
        chk("overflow_set", 32'(overflow), 32'd1);
        idle(6, 1'b1);

        // Reset mid-line, then a fresh line.
        line_px = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'hFF};
        cyc(1'b1, 8'hFF, 8'h80, 1'b1, 1'b0);
        cyc(1'b1, 8'h00, 8'h80, 1'b1, 1'b0);
        cyc(1'b1, 8'hFF, 8'h80, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 8'h80, 1'b1, 1'b1);
        chk("rst_valid", 32'(rle_valid), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        feed_line(8'h80, 1'b1);
        idle(3, 1'b1);

        // Values around the threshold (hysteresis pattern).
        line_px = '{8'h90, 8'h75, 8'h7F, 8'h90, 8'h6F, 8'h90, 8'h90, 8'h90};
        feed_line(8'h80, 1'b1);
        idle(3, 1'b1);

        // Randomized traffic: gaps, backpressure, per-cycle threshold changes, resets.
        e_prev = 8'h80;
        for (int n = 0; n < 1500; n++) begin
            logic       v, rdy, r;
            logic [7:0] t, e;
            v   = ($urandom_range(0, 3) != 0);
            rdy = ((n / 64) % 3 == 2) ? ($urandom_range(0, 7) == 0)
                                      : ($urandom_range(0, 3) != 0);
            r   = ($urandom_range(0, 299) == 0);
            t   = 8'($urandom_range(96, 160));
            case ($urandom_range(0, 3))
                0:       e = 8'($urandom);
                1:       e = 8'($urandom_range(80, 176));
                default: e = e_prev;
            endcase
            e_prev = e;
            cyc(v, e, t, rdy, r);
        end
        idle(8, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/edge_rle_packer.md
Name: edge_rle_packer

Overview:
- Downstream consumer of the Sobel pipeline's 8-bit edge magnitude stream (one pixel per clock while valid).
- Thresholds each pixel to a binary edge/no-edge class.
- Run-length encodes each image line and buffers the encoded words in a small FIFO for the downlink formatter.
- The input stream cannot stall, so FIFO overflow is detected and flagged, never back-pressured.

Parameters:
- IMG_WIDTH, 3000, pixels per line; the column counter wraps at this value.
- RUN_W, 14, run-length field width; the maximum encodable run is 2^RUN_W-1.
- FIFO_DEPTH, 16, output FIFO depth in words; must be a power of two and at least 2.
- HYST, 16, hysteresis margin in magnitude units (used only with the optional feature).

Ports:
- clk, input, 1: single clock domain, rising edge.
- rst, input, 1: synchronous, active-high reset.
- valid, input, 1: edge_in carries a pixel this cycle.
- edge_in, input, 8: Sobel edge magnitude, unsigned.
- thresh, input, 8: threshold, sampled only on the first pixel of each line (col==0).
- rle_valid, output, 1: the FIFO head word is present.
- rle_ready, input, 1: the consumer accepts the head word.
- rle_data, output, RUN_W+2: encoded word {class[RUN_W+1], eol[RUN_W], len[RUN_W-1:0]}.
- overflow, output, 1: sticky flag, set when any word has been dropped.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - col=0, run_len=0, FIFO empty.
  - rle_valid=0, rle_data=0, overflow=0.
  - The latched threshold is set to 128.
  - Reset mid-line discards the partial run; the next valid pixel is treated as col 0.
- Classification:
  - bit = (edge_in >= thr_latched). Comparison is unsigned, inclusive.
  - At col==0, thr_latched <= thresh, and the current pixel is compared against the incoming thresh value.
- Column counter: increments on each valid pixel; wraps IMG_WIDTH-1 -> 0. valid=0 holds all state.
- Run state, per valid pixel:
  - col==0: cur_bit<=bit, run_len<=1.
  - Otherwise, if bit==cur_bit and run_len<2^RUN_W-1: run_len<=run_len+1.
  - Otherwise: push {cur_bit,0,run_len}, then cur_bit<=bit, run_len<=1.
  - The saturation split emits a word of the same class. A split on the last pixel follows the two-word case below.
- End of line (col==IMG_WIDTH-1): the run that includes this pixel is pushed with eol=1.
  - If this pixel also terminates the prior run, two words are pushed in the same cycle, in this order: {cur_bit,0,run_len}, then {bit,1,1}.
  - The FIFO write port supports 0, 1 or 2 pushes per cycle.
- The sum of len over one line always equals IMG_WIDTH. Exactly one eol word is produced per line.
- FIFO:
  - First-word-fall-through on registered storage.
  - A word pushed at edge N is visible on rle_valid/rle_data after edge N (pipeline latency 1 clock from the terminating pixel).
  - Pop on rle_valid && rle_ready.
  - A simultaneous pop and push is allowed when full: the pop frees space in the same cycle.
  - rle_data holds its value while rle_valid=1 and rle_ready=0.
- Overflow:
  - If free space (after the same-cycle pop) is less than the words to push, all words of that cycle are dropped.
  - overflow<=1, and stays set until rst.
  - Run/column state advances normally regardless.
- rle_valid=0 when the FIFO is empty. rle_data is don't-care when rle_valid=0 but is driven, not X.

Optional Feature:
- Macro EDGE_RLE_HYST_EN.
- When defined: for col!=0, bit = cur_bit ? (edge_in >= sat0(thr_latched-HYST)) : (edge_in >= thr_latched). This suppresses single-pixel flicker at the threshold. col==0 uses the plain threshold.
- When undefined: plain threshold everywhere, and the HYST parameter is unused.

Test Plan:
1. IMG_WIDTH=8, thresh=128, rle_ready=1; line 00,00,C8,C8,C8,00,00,00 -> words {0,0,2}, {1,0,3}, {0,1,3}, each 1 clk after its terminating pixel.
2. IMG_WIDTH=8, seven 00 then FF -> {0,0,7} and {1,1,1} pushed in the same cycle; read out in that order on consecutive pops.
3. FIFO_DEPTH=4, rle_ready=0, IMG_WIDTH=8, line 00,FF,00,FF,00,FF,00,FF -> first 4 words retained in order; overflow=1 from the 5th-word cycle; releasing rle_ready drains exactly 4 words.
4. RUN_W=2, IMG_WIDTH=8, all 00 -> {0,0,3}, {0,0,3}, {0,1,2}; per-line len sum = 8.
5. rst asserted after 3 pixels of a line -> rle_valid=0 and overflow=0 on the next clock; the following 8 pixels encode as a fresh line, with eol on the 8th.
6. With EDGE_RLE_HYST_EN defined, thresh=128, HYST=16, IMG_WIDTH=8; line 90,75,7F,90,6F,90,90,90 -> {1,0,4}, {0,0,1}, {1,1,3}. Without the macro -> {1,0,1}, {0,0,2}, {1,0,1}, {0,0,1}, {1,1,3}.
